wb_arbiter2: RTL and testbench
==============================

# wb_arbiter2

Two-master Wishbone arbiter with bus-timeout watchdog for the Zet SoC 16-bit bus. It sits between the `zet` CPU master port (m0) and a second master (m1: DMA, debug monitor or bootstrap loader) on one side, and the `wb_switch` master port on the other. Access is granted round-robin, and each grant is held for a whole `cyc` transaction. Any slave that never acks, such as an unpopulated `wb_switch` slot tied to `ack=0`, is terminated after a bounded time so the CPU cannot hang.

## Interface
Parameters:
- `TIMEOUT`, default 255: number of cycles `s_stb_o` may be outstanding without `s_ack_i` before the watchdog terminates the access; legal range 2..255.
- `ERR_DATA`, default 16'hFFFF: read data returned to the master on a timed-out access.

Ports (clock and reset first):
- `wb_clk_i` in 1: the only clock, the CPU bus clock (12.5 MHz).
- `wb_rst_ni` in 1: reset, asynchronous and active-low.
- `mN_dat_i` in 16, N=0,1: master write data.
- `mN_dat_o` out 16: read data to the master.
- `mN_adr_i` in 19: word address [19:1].
- `mN_tga_i` in 1: 1 = I/O space.
- `mN_sel_i` in 2: byte lanes.
- `mN_we_i` in 1: write enable.
- `mN_cyc_i` in 1: cycle.
- `mN_stb_i` in 1: strobe.
- `mN_ack_o` out 1: acknowledge.
- `s_dat_o`, `s_adr_o[19:1]`, `s_tga_o`, `s_sel_o`, `s_we_o`, `s_cyc_o`, `s_stb_o` out: shared master port to `wb_switch`.
- `s_dat_i` in 16: read data from `wb_switch`.
- `s_ack_i` in 1: acknowledge from `wb_switch`.
- `to_err_o` out 1: one-cycle pulse on each timeout.
- `to_adr_o` out 20: `{tga,adr}` of the last timed-out access.

## Operation
State machine with states IDLE, G0 and G1. A register `last` records the most recent grantee.
- **IDLE:** all `s_*` control outputs are 0.
  - Only `m0_cyc_i` asserted: go to G0.
  - Only `m1_cyc_i` asserted: go to G1.
  - Both asserted: grant the master that is not `last`.
  - Neither asserted: stay in IDLE.
- **GN:**
  - `s_*` outputs pass combinationally from master N.
  - `mN_ack_o` = `s_ack_i` OR the watchdog ack.
  - The other master's `ack_o` is 0.
  - Both `mN_dat_o` = `s_dat_i`, except that during a watchdog ack the granted master sees `ERR_DATA`.
  - Set `last` = N on entry.
  - Remain in GN while `mN_cyc_i` = 1. Multiple strobes (e.g. locked or unaligned CPU pairs) stay in one grant.
  - When `mN_cyc_i` = 0, return to IDLE.
- **Watchdog:**
  - 8-bit counter, cleared when `s_stb_o` = 0 or `s_ack_i` = 1.
  - Increments each cycle that `s_stb_o` = 1 and `s_ack_i` = 0.
  - On the cycle the count equals `TIMEOUT`: assert `mN_ack_o` with `ERR_DATA`, force `s_stb_o` = 0, pulse `to_err_o`, latch `to_adr_o`, and clear the counter.
- **Boundary conditions:**
  - `s_ack_i` = 1 in the same cycle the count reaches `TIMEOUT`: the real ack wins (real data, no `to_err_o`).
  - A master drops `cyc` while unacked: return to IDLE and clear the counter; no error.
  - Reset asserted mid-transaction: immediately enter IDLE; `last` = 1 (so m0 wins the first contention); counter = 0; `to_adr_o` = 0. Every output is 0 while in reset.

## Timing
- Arbitration latency: `cyc` and `stb` seen in IDLE at cycle k gives `s_cyc_o`/`s_stb_o` at cycle k+1.
- Data and ack path in GN: zero added latency (combinational).
- One dead cycle in IDLE always separates two grants.
- Worst-case wait for a contending master is one full transaction of the other master plus 1 cycle.
- Timeout ack occurs `TIMEOUT` cycles after the first cycle of `s_stb_o`.
- `to_err_o` is high for exactly 1 cycle per timeout.

## Structure
- Package `wb_arb_pkg` holds:
  - state encoding (IDLE=2'd0, G0=2'd1, G1=2'd2);
  - `DEF_TIMEOUT` = 8'd255;
  - `DEF_ERR_DATA` = 16'hFFFF.
- Sub-module `wb_watchdog`: counter, compare, and the error-ack pulse. Inputs: `stb`, `ack`, `clr`. Outputs: `to_ack`, `to_pulse`.
- Top level: the FSM and the combinational muxes.

## Test plan
- **m0 only:** a read of 0xFFE00 with the slave acking after 2 cycles → `s_cyc_o` one cycle after the request; `m0_ack_o` after 2 cycles with slave data; `m1_ack_o` = 0 throughout.
- **Simultaneous request after reset:** m0 and m1 both assert `cyc` → G0 first; then IDLE for 1 cycle; then G1.
- **Contention with m0 re-requesting back-to-back:** m0 requests again immediately while m1 waits → grant order m1, m0, m1 (alternation); neither master is starved.
- **Read of I/O 0x3F8 with `s_ack_i` stuck at 0, `TIMEOUT`=16:**
  - `m0_ack_o` exactly 16 cycles after the first `s_stb_o`;
  - `m0_dat_o` = 16'hFFFF;
  - `to_err_o` is a 1-cycle pulse;
  - `to_adr_o` = 20'h801FC.
- **`s_ack_i` arrives on the same cycle the count reaches `TIMEOUT`:** real data is delivered; `to_err_o` stays 0; `to_adr_o` is unchanged.
- **Reset mid-transaction:** assert `wb_rst_ni`=0 during G1 → `s_cyc_o` = 0 asynchronously. After release, contention gives m0 first.

Source files
------------

// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// wb_arb_pkg : shared types and defaults for the two-master Wishbone arbiter
// Rev 1.0
// ============================================================================
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } arb_state_e;

    localparam logic [7:0]  DEF_TIMEOUT  = 8'd255;
    localparam logic [15:0] DEF_ERR_DATA = 16'hFFFF;

    // One master's request bundle, muxed as a unit onto the shared port.
    typedef struct packed {
        logic [15:0] dat;
        logic [18:0] adr;
        logic        tga;
        logic [1:0]  sel;
        logic        we;
        logic        cyc;
        logic        stb;
    } wb_req_t;

    // Round-robin pick from IDLE: on contention the master that was not last wins.
    function automatic arb_state_e next_grant(input logic cyc0, input logic cyc1, input logic last);
        if (cyc0 && (!cyc1 || last))
            return ST_G0;
        else if (cyc1)
            return ST_G1;
        return ST_IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_watchdog.sv
`default_nettype none
// ============================================================================
// wb_watchdog : bus-timeout counter that terminates strobes nobody acks
// Rev 1.0
// ============================================================================
module wb_watchdog
    import wb_arb_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic stb_i,
    input  logic ack_i,
    input  logic clr_i,
    output logic to_ack_o,
    output logic to_pulse_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       hit;

    // A real ack in the same cycle always beats the timeout.
    assign hit = stb_i & ~ack_i & ~clr_i & (cnt_q == TIMEOUT);

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clr_i || !stb_i || ack_i || hit)
            cnt_d = 8'd0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= 8'd0;
        else
            cnt_q <= cnt_d;
    end

    assign to_ack_o   = hit;
    assign to_pulse_o = hit;

endmodule
`default_nettype wire

// File: rtl/wb_arbiter2.sv
`default_nettype none
// ============================================================================
// wb_arbiter2 : two-master round-robin Wishbone arbiter with bus watchdog
// Rev 1.0
// ============================================================================
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter logic [7:0]  TIMEOUT  = DEF_TIMEOUT,
    parameter logic [15:0] ERR_DATA = DEF_ERR_DATA
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,

    input  logic [15:0] m0_dat_i,
    output logic [15:0] m0_dat_o,
    input  logic [19:1] m0_adr_i,
    input  logic        m0_tga_i,
    input  logic [1:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,

    input  logic [15:0] m1_dat_i,
    output logic [15:0] m1_dat_o,
    input  logic [19:1] m1_adr_i,
    input  logic        m1_tga_i,
    input  logic [1:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,

    output logic [15:0] s_dat_o,
    output logic [19:1] s_adr_o,
    output logic        s_tga_o,
    output logic [1:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [15:0] s_dat_i,
    input  logic        s_ack_i,

    output logic        to_err_o,
    output logic [19:0] to_adr_o
);

    arb_state_e  state_q;
    logic        last_q;
    logic [19:0] to_adr_q;

    arb_state_e  idle_next;
    wb_req_t     req0;
    wb_req_t     req1;
    wb_req_t     gnt;
    logic        in_g0;
    logic        in_g1;
    logic        wd_ack;
    logic        wd_pulse;

    always_comb begin
        req0.dat = m0_dat_i;
        req0.adr = m0_adr_i;
        req0.tga = m0_tga_i;
        req0.sel = m0_sel_i;
        req0.we  = m0_we_i;
        req0.cyc = m0_cyc_i;
        req0.stb = m0_stb_i;

        req1.dat = m1_dat_i;
        req1.adr = m1_adr_i;
        req1.tga = m1_tga_i;
        req1.sel = m1_sel_i;
        req1.we  = m1_we_i;
        req1.cyc = m1_cyc_i;
        req1.stb = m1_stb_i;
    end

    // The shared port is fully quiet in IDLE, so reset also quiets every output.
    always_comb begin
        gnt = '0;
        case (state_q)
            ST_G0:   gnt = req0;
            ST_G1:   gnt = req1;
            default: gnt = '0;
        endcase
    end

    assign idle_next = next_grant(m0_cyc_i, m1_cyc_i, last_q);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= idle_next;
                    if (idle_next != ST_IDLE)
                        last_q <= (idle_next == ST_G1);
                end
                ST_G0:   if (!m0_cyc_i) state_q <= ST_IDLE;
                ST_G1:   if (!m1_cyc_i) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Watchdog sees the master's raw strobe; the forced-low s_stb_o would loop back.
    wb_watchdog #(
        .TIMEOUT    (TIMEOUT)
    ) u_watchdog (
        .clk_i      (wb_clk_i),
        .rst_ni     (wb_rst_ni),
        .stb_i      (gnt.stb),
        .ack_i      (s_ack_i),
        .clr_i      (~gnt.cyc),
        .to_ack_o   (wd_ack),
        .to_pulse_o (wd_pulse)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            to_adr_q <= 20'd0;
        else if (wd_pulse)
            to_adr_q <= {gnt.tga, gnt.adr};
    end

    assign s_dat_o  = gnt.dat;
    assign s_adr_o  = gnt.adr;
    assign s_tga_o  = gnt.tga;
    assign s_sel_o  = gnt.sel;
    assign s_we_o   = gnt.we;
    assign s_cyc_o  = gnt.cyc;
    assign s_stb_o  = gnt.stb & ~wd_ack;

    assign in_g0    = (state_q == ST_G0);
    assign in_g1    = (state_q == ST_G1);

    assign m0_ack_o = in_g0 & (s_ack_i | wd_ack);
    assign m1_ack_o = in_g1 & (s_ack_i | wd_ack);

    assign m0_dat_o = (in_g0 && wd_ack) ? ERR_DATA : ((in_g0 || in_g1) ? s_dat_i : 16'd0);
    assign m1_dat_o = (in_g1 && wd_ack) ? ERR_DATA : ((in_g0 || in_g1) ? s_dat_i : 16'd0);

    assign to_err_o = wd_pulse;
    assign to_adr_o = to_adr_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
`default_nettype none
// ============================================================================
// tb_wb_arbiter2 : directed and randomized checks of the two-master arbiter
// Rev 1.0
// ============================================================================
module tb_wb_arbiter2;
    import wb_arb_pkg::*;

    localparam int          TO   = 16;
    localparam logic [15:0] ERRD = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [15:0] mdi  [2];
    logic [19:1] madr [2];
    logic        mtga [2];
    logic [1:0]  msel [2];
    logic        mwe  [2];
    logic        mcyc [2];
    logic        mstb [2];
    logic [15:0] mdo  [2];
    logic        mack [2];

    logic [15:0] s_dat_o;
    logic [19:1] s_adr_o;
    logic        s_tga_o;
    logic [1:0]  s_sel_o;
    logic        s_we_o;
    logic        s_cyc_o;
    logic        s_stb_o;
    logic [15:0] s_dat_i;
    logic        s_ack_i;
    logic        to_err_o;
    logic [19:0] to_adr_o;

    int errors = 0;
    int checks = 0;

    wb_arbiter2 #(
        .TIMEOUT  (8'(TO)),
        .ERR_DATA (ERRD)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .m0_dat_i  (mdi[0]),
        .m0_dat_o  (mdo[0]),
        .m0_adr_i  (madr[0]),
        .m0_tga_i  (mtga[0]),
        .m0_sel_i  (msel[0]),
        .m0_we_i   (mwe[0]),
        .m0_cyc_i  (mcyc[0]),
        .m0_stb_i  (mstb[0]),
        .m0_ack_o  (mack[0]),
        .m1_dat_i  (mdi[1]),
        .m1_dat_o  (mdo[1]),
        .m1_adr_i  (madr[1]),
        .m1_tga_i  (mtga[1]),
        .m1_sel_i  (msel[1]),
        .m1_we_i   (mwe[1]),
        .m1_cyc_i  (mcyc[1]),
        .m1_stb_i  (mstb[1]),
        .m1_ack_o  (mack[1]),
        .s_dat_o   (s_dat_o),
        .s_adr_o   (s_adr_o),
        .s_tga_o   (s_tga_o),
        .s_sel_o   (s_sel_o),
        .s_we_o    (s_we_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .to_err_o  (to_err_o),
        .to_adr_o  (to_adr_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_req(input int m);
        mcyc[m] = 1'b1;
        mstb[m] = 1'b1;
        madr[m] = 19'($urandom);
        mtga[m] = 1'($urandom);
        msel[m] = 2'($urandom);
        mwe[m]  = 1'($urandom);
        mdi[m]  = 16'($urandom);
    endtask

    // Waits for master exp to own the bus, acks it once, then drops its cyc.
    task automatic serve(input int exp, input bit again, input int exp_wait);
        int          waited = -1;
        logic [15:0] d;
        d = 16'hA5C0 + 16'(exp);
        for (int i = 0; i < 8; i++) begin
            tick;
            s_ack_i = 1'b0;
            #1;
            if (s_stb_o) begin
                waited = i;
                break;
            end
        end
        check("grant_wait", 64'(waited), 64'(exp_wait));
        if (waited >= 0) begin
            check("grant_adr", 64'(s_adr_o), 64'(madr[exp]));
            s_ack_i = 1'b1;
            s_dat_i = d;
            #1;
            check("grant_ack", {mack[exp], mack[1-exp], mdo[exp]}, {1'b1, 1'b0, d});
        end
        tick;
        s_ack_i   = 1'b0;
        mcyc[exp] = 1'b0;
        mstb[exp] = 1'b0;
        #1;
        check("drop_passthru", 64'(s_cyc_o), 64'd0);
        if (again) begin
            tick;
            mcyc[exp] = 1'b1;
            mstb[exp] = 1'b1;
            #1;
            check("dead_cycle", 64'(s_cyc_o), 64'd0);
        end
    endtask

    initial begin : main
        logic        saw;
        int          owner;
        bit          mlast;
        int          wcnt;
        logic [19:0] mto;
        logic        tmo;
        logic [40:0] e_bus;
        logic        e_ack [2];
        logic [15:0] e_dat [2];
        logic        prev_ack [2];

        for (int m = 0; m < 2; m++) begin
            mdi[m] = 16'h0; madr[m] = 19'h0; mtga[m] = 1'b0; msel[m] = 2'b11;
            mwe[m] = 1'b0; mcyc[m] = 1'b1; mstb[m] = 1'b1;
        end
        s_dat_i = 16'h1234;
        s_ack_i = 1'b1;

        // Reset: requests and slave activity present, yet everything must read 0
        repeat (2) @(posedge clk);
        #1;
        check("rst_bus", {s_cyc_o, s_stb_o, s_we_o, s_tga_o, s_sel_o, s_adr_o, s_dat_o}, 64'd0);
        check("rst_mst", {mack[0], mack[1], mdo[0], mdo[1]}, 64'd0);
        check("rst_to", {to_err_o, to_adr_o}, 64'd0);

        mcyc[0] = 1'b0; mstb[0] = 1'b0; mcyc[1] = 1'b0; mstb[1] = 1'b0;
        s_ack_i = 1'b0;
        rst_n = 1'b1;

        // Contention straight after reset, both masters re-requesting at once
        madr[0] = 19'h11111;
        madr[1] = 19'h62222;
        tick;
        mcyc[0] = 1'b1; mstb[0] = 1'b1; mcyc[1] = 1'b1; mstb[1] = 1'b1;
        serve(0, 1'b1, 0);
        serve(1, 1'b1, 0);
        serve(0, 1'b0, 0);
        serve(1, 1'b0, 1);

        // m0 alone: read of byte address 0xFFE00
        tick;
        madr[0] = 19'h7FF00; mtga[0] = 1'b0; mwe[0] = 1'b0;
        mcyc[0] = 1'b1; mstb[0] = 1'b1;
        #1;
        check("m0_req_latency", 64'(s_cyc_o), 64'd0);
        tick;
        #1;
        check("m0_grant", {s_cyc_o, s_stb_o, s_adr_o, mack[0], mack[1]}, {1'b1, 1'b1, 19'h7FF00, 1'b0, 1'b0});
        tick;
        s_ack_i = 1'b1;
        s_dat_i = 16'hBEEF;
        #1;
        check("m0_read", {mack[0], mack[1], mdo[0], mdo[1]}, {1'b1, 1'b0, 16'hBEEF, 16'hBEEF});
        tick;
        s_ack_i = 1'b0;
        mcyc[0] = 1'b0; mstb[0] = 1'b0;

        // Timeout on I/O 0x3F8 with a dead slave
        tick;
        madr[0] = 19'h001FC; mtga[0] = 1'b1;
        mcyc[0] = 1'b1; mstb[0] = 1'b1;
        saw = 1'b0;
        for (int i = 0; i <= TO; i++) begin
            tick;
            #1;
            if (i < TO) saw = saw | mack[0] | to_err_o;
        end
        check("to_early", 64'(saw), 64'd0);
        check("to_ack", {mack[0], mdo[0], to_err_o, s_stb_o, mack[1]}, {1'b1, ERRD, 1'b1, 1'b0, 1'b0});
        tick;
        #1;
        check("to_pulse_len", {to_err_o, mack[0], s_stb_o}, {1'b0, 1'b0, 1'b1});
        check("to_adr", 64'(to_adr_o), 64'h801FC);
        tick;
        mcyc[0] = 1'b0; mstb[0] = 1'b0; mtga[0] = 1'b0;

        // Real ack lands exactly when the count reaches TIMEOUT
        tick;
        madr[1] = 19'h12345; mtga[1] = 1'b0;
        mcyc[1] = 1'b1; mstb[1] = 1'b1;
        saw = 1'b0;
        for (int i = 0; i <= TO; i++) begin
            tick;
            s_ack_i = (i == TO);
            s_dat_i = (i == TO) ? 16'h1357 : 16'h0000;
            #1;
            if (i < TO) saw = saw | mack[1] | to_err_o;
        end
        check("race_early", 64'(saw), 64'd0);
        check("race_ack", {mack[1], mdo[1], to_err_o}, {1'b1, 16'h1357, 1'b0});
        tick;
        s_ack_i = 1'b0;
        mcyc[1] = 1'b0; mstb[1] = 1'b0;
        #1;
        check("race_to_adr", 64'(to_adr_o), 64'h801FC);

        // Reset in the middle of an m1 grant
        tick;
        madr[1] = 19'h62222;
        mcyc[1] = 1'b1; mstb[1] = 1'b1;
        tick;
        #1;
        check("g1_before_rst", 64'(s_cyc_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {s_cyc_o, s_stb_o, mack[1], to_adr_o}, 64'd0);
        madr[0] = 19'h11111;
        mcyc[0] = 1'b1; mstb[0] = 1'b1;
        tick;
        tick;
        rst_n = 1'b1;
        serve(0, 1'b0, 0);
        mcyc[1] = 1'b0; mstb[1] = 1'b0;
        tick;
        tick;

        // Randomized traffic against a cycle-level behavioural model
        owner = -1;
        mlast = 1'b0;
        wcnt  = 0;
        mto   = 20'd0;
        prev_ack[0] = 1'b0;
        prev_ack[1] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            tick;
            for (int m = 0; m < 2; m++) begin
                if (mcyc[m]) begin
                    if (prev_ack[m]) begin
                        if ($urandom_range(0, 1) == 0) begin
                            mcyc[m] = 1'b0;
                            mstb[m] = 1'b0;
                        end else begin
                            rand_req(m);
                        end
                    end
                end else if ($urandom_range(0, 4) < 2) begin
                    rand_req(m);
                end
            end
            s_ack_i = ($urandom_range(0, 9) == 0);
            s_dat_i = 16'($urandom);
            #1;

            tmo      = 1'b0;
            e_bus    = '0;
            e_ack[0] = 1'b0; e_ack[1] = 1'b0;
            e_dat[0] = 16'd0; e_dat[1] = 16'd0;
            if (owner >= 0) begin
                tmo = mstb[owner] && !s_ack_i && (wcnt == TO);
                e_bus = {mcyc[owner], mstb[owner] & ~tmo, mwe[owner], mtga[owner],
                         msel[owner], madr[owner], mdi[owner]};
                e_dat[0] = s_dat_i;
                e_dat[1] = s_dat_i;
                if (tmo) e_dat[owner] = ERRD;
                e_ack[owner] = s_ack_i | tmo;
            end
            check("rnd_bus", {s_cyc_o, s_stb_o, s_we_o, s_tga_o, s_sel_o, s_adr_o, s_dat_o}, 64'(e_bus));
            check("rnd_mst", {mack[0], mack[1], mdo[0], mdo[1]}, {e_ack[0], e_ack[1], e_dat[0], e_dat[1]});
            check("rnd_to", {to_err_o, to_adr_o}, {tmo, mto});
            prev_ack[0] = e_ack[0];
            prev_ack[1] = e_ack[1];

            if (owner < 0) begin
                wcnt = 0;
                if (mcyc[0] && mcyc[1]) owner = mlast ? 0 : 1;
                else if (mcyc[0])       owner = 0;
                else if (mcyc[1])       owner = 1;
                if (owner >= 0) mlast = (owner == 1);
            end else begin
                if (tmo) mto = {mtga[owner], madr[owner]};
                if (!mstb[owner] || s_ack_i || tmo) wcnt = 0;
                else                                wcnt = wcnt + 1;
                if (!mcyc[owner]) begin
                    owner = -1;
                    wcnt  = 0;
                end
            end
        end

        tick;
        mcyc[0] = 1'b0; mstb[0] = 1'b0; mcyc[1] = 1'b0; mstb[1] = 1'b0;
        s_ack_i = 1'b0;
        repeat (3) tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
